// File: rtl/vga_frame_sched_pkg.sv
// Shared definitions for the VGA frame scheduler: 640x480@60 timing constants,
// colour width/type and the scheduler FSM state encoding.
// Imported by the scheduler top and its testbench.
package vga_frame_sched_pkg;

  // Horizontal/vertical counter limits of the 800x525 raster.
  localparam int H_LAST   = 799;
  localparam int V_LAST   = 524;
  localparam int VB_START = 480;
  localparam int H_VIS    = 640;
  localparam int V_VIS    = 480;

  // 4:4:4 colour.
  localparam int RGB_W = 12;
  typedef logic [RGB_W-1:0] rgb_t;

  // ACTIVE : visible area, no grants.
  // ARB    : one-cycle arbitration slot inside the blanking window.
  // GRANT  : one engine owns the update window.
  // WINDOW : blanking, nobody requesting.
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_ARB    = 2'd1,
    ST_GRANT  = 2'd2,
    ST_WINDOW = 2'd3
  } sched_state_t;

endpackage

// File: rtl/vga_frame_sched_if.sv
// Bundle between the sync generator / object engines and the frame scheduler.
// master: sync generator + object engines (drive timing, req/done, pixels).
// slave : the scheduler (drives gnt, frame_tick, busy, overrun, rgb).
interface vga_frame_sched_if #(
  parameter int N     = 4,
  parameter int RGB_W = 12
);
  // raster timing
  logic                 p_tick;
  logic                 video_on;
  logic [9:0]           pixel_x;
  logic [9:0]           pixel_y;
  // update-window handshake
  logic [N-1:0]         req;
  logic [N-1:0]         done;
  logic [N-1:0]         gnt;
  logic                 frame_tick;
  logic                 busy;
  logic                 overrun;
  // pixel layering
  logic [N-1:0]         obj_on;
  logic [N*RGB_W-1:0]   obj_rgb;
  logic [RGB_W-1:0]     bg_rgb;
  logic [RGB_W-1:0]     rgb;

  modport master (
    output p_tick, video_on, pixel_x, pixel_y, req, done, obj_on, obj_rgb, bg_rgb,
    input  gnt, frame_tick, busy, overrun, rgb
  );

  modport slave (
    input  p_tick, video_on, pixel_x, pixel_y, req, done, obj_on, obj_rgb, bg_rgb,
    output gnt, frame_tick, busy, overrun, rgb
  );
endinterface

// File: rtl/vga_frame_sched_rr_arbiter.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// searching circularly.
// Ports: req/ptr in; one-hot gnt, valid and the granted index out.
module vga_frame_sched_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid,
  output logic [PW-1:0] idx
);

  int k;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!valid && req[k]) begin
        valid  = 1'b1;
        gnt[k] = 1'b1;
        idx    = PW'(k);
      end
    end
  end

endmodule

// File: rtl/vga_frame_sched.sv
// Frame scheduler: opens a vertical-blanking update window per frame, shares it
// round-robin among N object engines (req/gnt/done) and layers object colours
// into a registered rgb output (1 pixel tick latency, lowest index on top).
// Ports: clk, reset (sync, active-high), bus (vga_frame_sched_if.slave).
// Optional: define VGA_SCHED_TIMEOUT_EN to revoke grants held TMO_CYCLES clks.
module vga_frame_sched #(
  parameter int N          = 4,
  parameter int RGB_W      = vga_frame_sched_pkg::RGB_W,
  parameter int VB_START   = vga_frame_sched_pkg::VB_START,
  parameter int V_LAST     = vga_frame_sched_pkg::V_LAST,
  parameter int H_LAST     = vga_frame_sched_pkg::H_LAST,
  parameter int TMO_CYCLES = 1023
) (
  input logic              clk,
  input logic              reset,
  vga_frame_sched_if.slave bus
);
  import vga_frame_sched_pkg::*;

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  sched_state_t     state;
  logic [N-1:0]     gnt_q;
  logic [PW-1:0]    cur_idx;
  logic [PW-1:0]    ptr;
  logic             busy_q;
  logic             overrun_q;
  logic             frame_tick_q;
  logic [RGB_W-1:0] rgb_q;

  logic             sof_evt;
  logic             eof_evt;
  logic             done_hit;
  logic [PW-1:0]    ptr_nxt;
  logic [N-1:0]     arb_gnt;
  logic             arb_vld;
  logic [PW-1:0]    arb_idx;
  logic [RGB_W-1:0] pix_sel;

`ifdef VGA_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  assign sof_evt = bus.p_tick && (bus.pixel_x == 10'(0))      && (bus.pixel_y == 10'(VB_START));
  assign eof_evt = bus.p_tick && (bus.pixel_x == 10'(H_LAST)) && (bus.pixel_y == 10'(V_LAST));

  // Only the granted engine's done counts; stray done bits are masked off.
  assign done_hit = (state == ST_GRANT) && |(bus.done & gnt_q);

  // Pointer always moves past whichever engine just lost the window.
  assign ptr_nxt = (cur_idx == PW'(N - 1)) ? '0 : cur_idx + PW'(1);

  vga_frame_sched_rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .valid (arb_vld),
    .idx   (arb_idx)
  );

  // Scan from the top down so the lowest-index object wins.
  always_comb begin
    pix_sel = bus.bg_rgb;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.obj_on[i]) pix_sel = bus.obj_rgb[i*RGB_W +: RGB_W];
    end
    if (!bus.video_on) pix_sel = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_ACTIVE;
      gnt_q        <= '0;
      cur_idx      <= '0;
      ptr          <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      rgb_q        <= '0;
`ifdef VGA_SCHED_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      frame_tick_q <= sof_evt;
      if (bus.p_tick) rgb_q <= pix_sel;

      // done beats a coincident frame end: no overrun, but the window closes.
      if (done_hit) begin
        ptr    <= ptr_nxt;
        gnt_q  <= '0;
        busy_q <= 1'b0;
        state  <= eof_evt ? ST_ACTIVE : ST_ARB;
      end else if (eof_evt) begin
        if (state == ST_GRANT) begin
          overrun_q <= 1'b1;
          ptr       <= ptr_nxt;
        end
        gnt_q  <= '0;
        busy_q <= 1'b0;
        state  <= ST_ACTIVE;
      end else begin
        case (state)
          ST_ACTIVE: if (sof_evt) state <= ST_ARB;
          ST_ARB: begin
            if (arb_vld) begin
              gnt_q   <= arb_gnt;
              cur_idx <= arb_idx;
              busy_q  <= 1'b1;
              state   <= ST_GRANT;
`ifdef VGA_SCHED_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              state <= ST_WINDOW;
            end
          end
          ST_GRANT: begin
`ifdef VGA_SCHED_TIMEOUT_EN
            // Stalled engine: take the window back, keep arbitrating.
            if (tmo_cnt == TW'(TMO_CYCLES - 1)) begin
              overrun_q <= 1'b1;
              ptr       <= ptr_nxt;
              gnt_q     <= '0;
              busy_q    <= 1'b0;
              state     <= ST_ARB;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
`endif
          end
          ST_WINDOW: if (|bus.req) state <= ST_ARB;
          default:   state <= ST_ACTIVE;
        endcase
      end
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.rgb        = rgb_q;

endmodule

// File: tb/tb_vga_frame_sched.sv
// Randomized bench for vga_frame_sched on a shrunken raster (16x12 pixels,
// blanking from line 8) so many frames fit in a short run.
// Engines answer grants with random delays, stall, or answer exactly at frame end.
module tb_vga_frame_sched;
  import vga_frame_sched_pkg::*;

  localparam int N         = 4;
  localparam int TB_H_LAST = 15;
  localparam int TB_V_LAST = 11;
  localparam int TB_VB     = 8;
  localparam int TB_TMO    = 16;
  localparam int NCYC      = 24000;
  localparam int RST2      = 10000;

  logic clk = 1'b0;
  logic reset;

  vga_frame_sched_if #(.N(N), .RGB_W(RGB_W)) bus ();

  vga_frame_sched #(
    .N(N), .RGB_W(RGB_W), .VB_START(TB_VB), .V_LAST(TB_V_LAST),
    .H_LAST(TB_H_LAST), .TMO_CYCLES(TB_TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int cyc);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model, stated in terms of "who owns the window" rather than states.
  int   m_ptr, m_cur, m_held;
  bit   m_arb;    // this cycle is an arbitration slot
  bit   m_open;   // inside the blanking update window
  bit   m_ovr, m_ftick;
  rgb_t m_rgb;

  function automatic rgb_t ref_pix();
    if (!bus.video_on) return '0;
    for (int i = 0; i < N; i++)
      if (bus.obj_on[i]) return bus.obj_rgb[i*RGB_W +: RGB_W];
    return bus.bg_rgb;
  endfunction

  task automatic model_step();
    bit sof, eof;
    if (reset) begin
      m_ptr = 0; m_cur = -1; m_held = 0; m_arb = 0; m_open = 0;
      m_ovr = 0; m_ftick = 0; m_rgb = '0;
      return;
    end
    sof = bus.p_tick && bus.pixel_x == 10'(0) && bus.pixel_y == 10'(TB_VB);
    eof = bus.p_tick && bus.pixel_x == 10'(TB_H_LAST) && bus.pixel_y == 10'(TB_V_LAST);
    m_ftick = sof;
    if (bus.p_tick) m_rgb = ref_pix();
    if (m_cur >= 0 && bus.done[m_cur]) begin
      m_ptr = (m_cur + 1) % N; m_cur = -1;
      m_arb = !eof; m_open = !eof;
    end else if (eof) begin
      if (m_cur >= 0) begin m_ovr = 1; m_ptr = (m_cur + 1) % N; m_cur = -1; end
      m_arb = 0; m_open = 0;
    end else if (m_arb) begin
      m_arb = 0;
      for (int k = 0; k < N; k++)
        if (m_cur < 0 && bus.req[(m_ptr + k) % N]) m_cur = (m_ptr + k) % N;
      m_held = 0;
    end else if (m_cur >= 0) begin
`ifdef VGA_SCHED_TIMEOUT_EN
      m_held++;
      if (m_held == TB_TMO) begin
        m_ovr = 1; m_ptr = (m_cur + 1) % N; m_cur = -1; m_arb = 1;
      end
`endif
    end else if (m_open) begin
      m_arb = (bus.req != '0);
    end else if (sof) begin
      m_open = 1; m_arb = 1;
    end
  endtask

  // Stimulus state
  int px, py, ph, mode;
  int tmr[N];
  bit armed[N];

  initial begin
    logic [N-1:0] dn;
    logic [N-1:0] flip;
    logic [31:0]  exp_gnt;
    bit           eof_next;

    px = 5; py = 3; ph = 0; mode = 0;
    for (int i = 0; i < N; i++) begin tmr[i] = -1; armed[i] = 0; end
    m_ptr = 0; m_cur = -1; m_held = 0; m_arb = 0; m_open = 0;
    m_ovr = 0; m_ftick = 0; m_rgb = '0;

    reset        = 1'b1;
    bus.p_tick   = 1'b0;
    bus.video_on = 1'b0;
    bus.pixel_x  = 10'(px);
    bus.pixel_y  = 10'(py);
    bus.req      = N'($urandom_range(0, 15));
    bus.done     = '0;
    bus.obj_on   = '0;
    bus.obj_rgb  = '0;
    bus.bg_rgb   = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      model_step();
      exp_gnt = (m_cur >= 0) ? (32'd1 << m_cur) : 32'd0;
      check("gnt",        32'(bus.gnt),        exp_gnt,          cyc);
      check("busy",       32'(bus.busy),       32'(m_cur >= 0),  cyc);
      check("frame_tick", 32'(bus.frame_tick), 32'(m_ftick),     cyc);
      check("overrun",    32'(bus.overrun),    32'(m_ovr),       cyc);
      check("rgb",        32'(bus.rgb),        32'(m_rgb),       cyc);

      // Next cycle's inputs.
      reset = (cyc + 1 < 3) || (cyc + 1 >= RST2 && cyc + 1 < RST2 + 3);

      if (bus.p_tick) begin
        if (px == TB_H_LAST) begin
          px = 0;
          py = (py == TB_V_LAST) ? 0 : py + 1;
        end else begin
          px++;
        end
      end
      ph = (ph + 1) % 4;
      bus.p_tick   = (ph == 3);
      bus.pixel_x  = 10'(px);
      bus.pixel_y  = 10'(py);
      bus.video_on = (px < 12) && (py < TB_VB);
      bus.obj_on   = N'($urandom_range(0, 15));
      bus.obj_rgb  = (N*RGB_W)'({$urandom(), $urandom()});
      bus.bg_rgb   = RGB_W'($urandom());

      // New frame: fresh request pattern and engine behaviour
      // (0-3 normal, 4 all stall, 5 answer only at frame end).
      if (bus.p_tick && px == 0 && py == 0) begin
        mode    = $urandom_range(0, 5);
        bus.req = N'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 63) == 0) begin
        flip = '0;
        flip[$urandom_range(0, N-1)] = 1'b1;
        bus.req = bus.req ^ flip;
      end

      eof_next = bus.p_tick && px == TB_H_LAST && py == TB_V_LAST;
      dn = '0;
      for (int i = 0; i < N; i++) begin
        if (!bus.gnt[i]) begin
          armed[i] = 0; tmr[i] = -1;
        end else if (!armed[i]) begin
          armed[i] = 1;
          tmr[i] = (mode < 4 && $urandom_range(0, 9) != 0) ? int'($urandom_range(1, 12)) : -1;
        end else if (tmr[i] > 0) begin
          tmr[i]--;
        end
        if (armed[i] && tmr[i] == 0) begin dn[i] = 1'b1; tmr[i] = -1; end
      end
      if (mode == 5 && eof_next) dn = dn | bus.gnt;
      if ($urandom_range(0, 15) == 0) begin
        flip = '0;
        flip[$urandom_range(0, N-1)] = 1'b1;
        dn = dn | flip;
      end
      bus.done = dn;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_frame_sched.md
Name: vga_frame_sched

Overview:
- Display-side controller that sits directly downstream of the VGA sync generator.
- Detects frame boundaries and opens a vertical-blanking "update window".
- Round-robin arbitrates that window among N object engines that need to update positions/state once per frame, using a req/gnt/done handshake.
- Layers the objects' pixel colours into a single registered rgb output, which goes to the DAC pins.

Parameters:
- N, 4, number of object requesters (2..8).
- RGB_W, 12, colour width per object (4:4:4).
- VB_START, 480, first vertical line of blanking.
- V_LAST, 524, last vertical line of frame.
- H_LAST, 799, last horizontal count of a line.
- TMO_CYCLES, 1023, clk cycles a single grant may be held (used only with the optional feature).

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- p_tick  in  1  25 MHz pixel enable from the sync generator.
- video_on  in  1  visible-area flag.
- pixel_x  in  10  horizontal count.
- pixel_y  in  10  vertical count.
- req  in  N  per-object update request, level.
- done  in  N  per-object update complete, 1-clk pulse.
- obj_on  in  N  object pixel-hit flags for the current pixel.
- obj_rgb  in  N*RGB_W  concatenated object colours; object i occupies bits [i*RGB_W +: RGB_W].
- bg_rgb  in  RGB_W  background colour.
- gnt  out  N  one-hot update grant.
- frame_tick  out  1  1-clk pulse at start of blanking.
- busy  out  1  a grant is active.
- overrun  out  1  sticky: a grant was revoked at frame end.
- rgb  out  RGB_W  registered pixel colour.

Behaviour:
- Reset (synchronous, active-high, checked every clk edge):
  - gnt=0, frame_tick=0, busy=0, overrun=0, rgb=0.
  - Round-robin pointer=0; FSM=ACTIVE.
  - Reset asserted mid-grant drops gnt on the next edge; no done is expected afterwards.
- Events:
  - sof_evt = p_tick && pixel_x==0 && pixel_y==VB_START.
  - eof_evt = p_tick && pixel_x==H_LAST && pixel_y==V_LAST.
- frame_tick: registered copy of sof_evt; exactly one clk wide, once per frame.
- FSM (state update on every clk, not gated by p_tick):
  - ACTIVE: gnt=0. On sof_evt go to ARB.
  - ARB (1 cycle):
    - If req==0, go to WINDOW.
    - Otherwise grant the first requester at or after pointer (circular search). Set gnt one-hot, busy=1, go to GRANT.
  - GRANT: gnt held stable.
    - On done[k] for the granted k: pointer=(k+1) mod N, gnt=0, busy=0, go to ARB.
    - done on non-granted bits is ignored.
  - WINDOW: idle in blanking; go to ARB as soon as req!=0.
  - eof_evt has priority in any state:
    - If a grant is active, it is revoked, overrun is set, and the pointer advances past the revoked k.
    - Go to ACTIVE.
- Each requester receives at most one grant per window until every pending requester has been served (round robin).
- A req deasserted while its grant is active has no effect; the grant ends only on done or revocation.
- Simultaneous done and eof_evt in the same cycle: treat as done (no overrun); FSM goes to ACTIVE.
- overrun clears only on reset.
- rgb pipeline: updated only on p_tick. Latency is 1 pixel tick.
  - !video_on gives 0.
  - Otherwise the lowest index i with obj_on[i]=1 gives obj_rgb[i].
  - Otherwise bg_rgb.

Optional Feature:
- Macro: VGA_SCHED_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on each grant and increments every clk in GRANT.
  - Reaching TMO_CYCLES revokes the grant, sets overrun, advances the pointer, and returns to ARB. The window continues.
- Undefined: no counter; a grant ends only on done or eof_evt.

Decomposition:
- Shared package vga_pkg:
  - Timing constants H_LAST, V_LAST, VB_START, the 640/480 visible limits.
  - RGB_W, the colour typedef, and the FSM state encoding (ACTIVE, ARB, GRANT, WINDOW).
- One natural sub-module: rr_arbiter (request vector plus pointer in, one-hot grant plus valid out; combinational).
- The FSM, event detect and rgb register stay in the top module.

Test Plan:
- Reset: hold reset 3 clk during a simulated frame → all outputs 0; first frame_tick occurs at pixel_y=480, pixel_x=0, width 1 clk.
- Round robin: N=4, req=4'b1111, each granted engine pulses done 10 clk later → gnt sequence 0001,0010,0100,1000 in one window; the next frame starts at 0001 again (pointer wrapped to 0).
- Fairness: req=4'b1010 with pointer=2 → first gnt=1000, then 0010.
- Revocation: an engine never sends done → gnt drops on the cycle after pixel (799,524); overrun=1 and stays 1; the next frame grants the next index.
- Simultaneous: done coincides with eof_evt → overrun stays 0 and FSM=ACTIVE.
- Layering: obj_on=4'b0110, obj_rgb[1]=12'hF00, obj_rgb[2]=12'h0F0, video_on=1 → rgb=12'hF00 one p_tick later; video_on=0 → rgb=0.
- With VGA_SCHED_TIMEOUT_EN, TMO_CYCLES=16: a stalled grant drops after 16 clk and the next requester is granted in the same window.
